// File: rtl/bist_resp_analyzer.sv
// -----------------------------------------------------------------------------
// bist_resp_analyzer
//
// Read-side response analyzer for the SRAM BIST. Each accepted BIST read is
// held in an alignment pipeline as long as the SRAM read latency. When the
// SRAM data returns, it is compared with the stored expected data. Results
// are reported as a per-read pulse, a sticky fail flag, a saturating fail
// count, and the address and syndrome of the first mismatch. Test completion
// is signalled to the BIST controller with a done/pass handshake.
//
// Parameters
//   ADDR_W  SRAM address width
//   DATA_W  SRAM data width
//   RD_LAT  SRAM read latency in cycles (1..4)
//   CNT_W   fail counter width
//
// Ports
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   start           pulse: clear results, flush pipeline, enter ACTIVE
//   test_end        pulse: last read issued, enter DRAIN
//   rd_en           BIST read issued this cycle (accepted only in ACTIVE)
//   rd_addr         address of that read
//   exp_data        expected data of that read
//   mem_q           SRAM read data, valid RD_LAT cycles after rd_en
//   cmp_valid       registered pulse: a compare completed
//   cmp_err         registered pulse: that compare mismatched
//   fail            sticky mismatch flag since start
//   fail_cnt        saturating mismatch count since start
//   first_fail_addr address of the first mismatch
//   first_fail_syn  mem_q ^ exp_data at the first mismatch
//   busy            state is ACTIVE or DRAIN
//   done            state is DONE
//   pass            done & ~fail
// -----------------------------------------------------------------------------
module bist_resp_analyzer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              test_end,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] mem_q,
  output logic              cmp_valid,
  output logic              cmp_err,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_syn,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [2:0] drain_q, drain_d;

  // Alignment pipeline: stage 0 holds a read accepted last cycle, stage
  // RD_LAT-1 lines up with the SRAM data on mem_q.
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  logic              cmp_valid_q, cmp_valid_d;
  logic              cmp_err_q,   cmp_err_d;
  logic              fail_q,      fail_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [ADDR_W-1:0] ffa_q,       ffa_d;
  logic [DATA_W-1:0] ffs_q,       ffs_d;

  logic              accept;
  logic              cmp_hit;
  logic [DATA_W-1:0] syn;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // start takes priority, so a read in the start cycle is never accepted.
  assign accept  = rd_en && (state_q == S_ACTIVE) && !start;
  assign cmp_hit = vld_q[RD_LAT-1];
  assign syn     = mem_q ^ exp_q[RD_LAT-1];

  // Next-state logic: FSM and result registers
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cmp_valid_d = 1'b0;
    cmp_err_d   = 1'b0;
    fail_d      = fail_q;
    cnt_d       = cnt_q;
    ffa_d       = ffa_q;
    ffs_d       = ffs_q;

    if (start) begin
      state_d = S_ACTIVE;
      fail_d  = 1'b0;
      cnt_d   = '0;
      ffa_d   = '0;
      ffs_d   = '0;
    end else begin
      unique case (state_q)
        S_ACTIVE: begin
          if (test_end) begin
            state_d = S_DRAIN;
            drain_d = 3'(RD_LAT - 1);
          end
        end
        S_DRAIN: begin
          if (drain_q == 3'd0) state_d = S_DONE;
          else                 drain_d = drain_q - 3'd1;
        end
        default: ;
      endcase

      // The compare is independent of state, so reads accepted up to the
      // test_end cycle still resolve while the FSM drains.
      if (cmp_hit) begin
        cmp_valid_d = 1'b1;
        cmp_err_d   = (syn != '0);
        if (syn != '0) begin
          fail_d = 1'b1;
          cnt_d  = sat_inc(cnt_q);
          if (!fail_q) begin
            ffa_d = addr_q[RD_LAT-1];
            ffs_d = syn;
          end
        end
      end
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      vld_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_err_q   <= 1'b0;
      fail_q      <= 1'b0;
      cnt_q       <= '0;
      ffa_q       <= '0;
      ffs_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_err_q   <= cmp_err_d;
      fail_q      <= fail_d;
      cnt_q       <= cnt_d;
      ffa_q       <= ffa_d;
      ffs_q       <= ffs_d;
      if (start) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Alignment pipeline payload; qualified by vld_q, so no reset needed
  always_ff @(posedge clk) begin
    addr_q[0] <= rd_addr;
    exp_q[0]  <= exp_data;
    for (int i = 1; i < RD_LAT; i++) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
  end

  assign cmp_valid       = cmp_valid_q;
  assign cmp_err         = cmp_err_q;
  assign fail            = fail_q;
  assign fail_cnt        = cnt_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_syn  = ffs_q;
  assign busy            = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && !fail_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_resp_analyzer
//
// Directed bench for bist_resp_analyzer. Three instances share the BIST-side
// stimulus: u_a (RD_LAT=1, CNT_W=8), u_b (RD_LAT=2, CNT_W=8) and
// u_c (RD_LAT=1, CNT_W=2). A small SRAM-return model delays the data the bench
// chooses for each read by 1 or 2 cycles to form mem_q.
// -----------------------------------------------------------------------------
module tb_bist_resp_analyzer;

  logic       clk = 1'b0;
  logic       rst_n, start, test_end, rd_en;
  logic [5:0] rd_addr;
  logic [7:0] exp_data, rdata;
  logic [7:0] mq1, mq2_s, mq2;

  logic       a_cv, a_ce, a_fail, a_busy, a_done, a_pass;
  logic [7:0] a_cnt, a_ffs;
  logic [5:0] a_ffa;
  logic       b_cv, b_ce, b_fail, b_busy, b_done, b_pass;
  logic [7:0] b_cnt, b_ffs;
  logic [5:0] b_ffa;
  logic       c_cv, c_ce, c_fail, c_busy, c_done, c_pass;
  logic [1:0] c_cnt;
  logic [7:0] c_ffs;
  logic [5:0] c_ffa;

  int n_chk = 0;
  int n_fail = 0;
  int cv_a, ce_a, cv_b;

  always #5 clk = ~clk;

  // SRAM return model: data chosen at issue time comes back 1 or 2 cycles later
  always @(posedge clk) begin
    mq1   <= rdata;
    mq2_s <= rdata;
    mq2   <= mq2_s;
  end

  bist_resp_analyzer #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .test_end(test_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .exp_data(exp_data), .mem_q(mq1),
    .cmp_valid(a_cv), .cmp_err(a_ce), .fail(a_fail), .fail_cnt(a_cnt),
    .first_fail_addr(a_ffa), .first_fail_syn(a_ffs),
    .busy(a_busy), .done(a_done), .pass(a_pass));

  bist_resp_analyzer #(.ADDR_W(6), .DATA_W(8), .RD_LAT(2), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .test_end(test_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .exp_data(exp_data), .mem_q(mq2),
    .cmp_valid(b_cv), .cmp_err(b_ce), .fail(b_fail), .fail_cnt(b_cnt),
    .first_fail_addr(b_ffa), .first_fail_syn(b_ffs),
    .busy(b_busy), .done(b_done), .pass(b_pass));

  bist_resp_analyzer #(.ADDR_W(6), .DATA_W(8), .RD_LAT(1), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .test_end(test_end),
    .rd_en(rd_en), .rd_addr(rd_addr), .exp_data(exp_data), .mem_q(mq1),
    .cmp_valid(c_cv), .cmp_err(c_ce), .fail(c_fail), .fail_cnt(c_cnt),
    .first_fail_addr(c_ffa), .first_fail_syn(c_ffs),
    .busy(c_busy), .done(c_done), .pass(c_pass));

  // Advance one cycle, sample 1 time unit after the edge, tally result pulses
  task automatic step();
    @(posedge clk);
    #1;
    cv_a += int'(a_cv);
    ce_a += int'(a_ce);
    cv_b += int'(b_cv);
  endtask

  task automatic rd(input logic [5:0] ad, input logic [7:0] ex,
                    input logic [7:0] dat, input logic te);
    rd_en = 1'b1; rd_addr = ad; exp_data = ex; rdata = dat; test_end = te;
    step();
    rd_en = 1'b0; test_end = 1'b0; rdata = 8'h00;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_counts();
    cv_a = 0; ce_a = 0; cv_b = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; test_end = 1'b0; rd_en = 1'b0;
    rd_addr = '0; exp_data = '0; rdata = '0;
    step(); step();
    n_chk++; if (a_cv !== 1'b0 || a_ce !== 1'b0) begin n_fail++; $display("FAIL reset_cmp: cv=%b ce=%b want 0 0", a_cv, a_ce); end
    n_chk++; if (a_fail !== 1'b0 || a_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fail: fail=%b cnt=%0d want 0 0", a_fail, a_cnt); end
    n_chk++; if (a_ffa !== 6'd0 || a_ffs !== 8'd0) begin n_fail++; $display("FAIL reset_first: addr=%h syn=%h want 0 0", a_ffa, a_ffs); end
    n_chk++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin n_fail++; $display("FAIL reset_status: busy=%b done=%b pass=%b want 0 0 0", a_busy, a_done, a_pass); end
    rst_n = 1'b1;
  endtask

  task automatic test_all_pass();
    do_start();
    n_chk++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL start_active: busy=%b done=%b want 1 0", a_busy, a_done); end
    clr_counts();
    for (int i = 0; i < 64; i++) rd(6'(i), 8'h55, 8'h55, i == 63);
    // now at test_end + 1
    n_chk++; if (a_done !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL pass_drain: done=%b busy=%b want 0 1", a_done, a_busy); end
    step();
    n_chk++; if (a_done !== 1'b1 || a_busy !== 1'b0 || a_pass !== 1'b1) begin n_fail++; $display("FAIL pass_done: done=%b busy=%b pass=%b want 1 0 1", a_done, a_busy, a_pass); end
    n_chk++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL pass_cnt: got %0d want 0", a_cnt); end
    n_chk++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL pass_b_early: done=%b want 0", b_done); end
    step();
    n_chk++; if (b_done !== 1'b1 || b_pass !== 1'b1) begin n_fail++; $display("FAIL pass_b_done: done=%b pass=%b want 1 1", b_done, b_pass); end
    n_chk++; if (cv_a !== 64 || ce_a !== 0) begin n_fail++; $display("FAIL pass_pulses: cv=%0d ce=%0d want 64 0", cv_a, ce_a); end
    n_chk++; if (cv_b !== 64) begin n_fail++; $display("FAIL pass_b_pulses: cv=%0d want 64", cv_b); end
  endtask

  task automatic test_single_fault();
    int err_a, err_b;
    err_a = -1; err_b = -1;
    do_start();
    clr_counts();
    for (int i = 0; i < 64; i++) begin
      rd(6'(i), 8'h55, (i == 42) ? 8'h5D : 8'h55, i == 63);
      if (a_ce && err_a < 0) err_a = i;
      if (b_ce && err_b < 0) err_b = i;
    end
    step(); step();
    // read 42 issued in iteration 42: RD_LAT+1 cycles later is iteration 43 / 44
    n_chk++; if (err_a !== 43) begin n_fail++; $display("FAIL single_err_time_a: iter %0d want 43", err_a); end
    n_chk++; if (err_b !== 44) begin n_fail++; $display("FAIL single_err_time_b: iter %0d want 44", err_b); end
    n_chk++; if (ce_a !== 1) begin n_fail++; $display("FAIL single_err_count: got %0d want 1", ce_a); end
    n_chk++; if (a_fail !== 1'b1 || a_cnt !== 8'd1) begin n_fail++; $display("FAIL single_fail: fail=%b cnt=%0d want 1 1", a_fail, a_cnt); end
    n_chk++; if (a_ffa !== 6'h2A || a_ffs !== 8'h08) begin n_fail++; $display("FAIL single_first: addr=%h syn=%h want 2a 08", a_ffa, a_ffs); end
    n_chk++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin n_fail++; $display("FAIL single_pass: done=%b pass=%b want 1 0", a_done, a_pass); end
    n_chk++; if (b_cnt !== 8'd1 || b_ffa !== 6'h2A || b_ffs !== 8'h08) begin n_fail++; $display("FAIL single_b: cnt=%0d addr=%h syn=%h want 1 2a 08", b_cnt, b_ffa, b_ffs); end
  endtask

  task automatic test_multi_fault();
    do_start();
    for (int i = 0; i < 20; i++)
      rd(6'(i), 8'h55, (i == 3) ? 8'h54 : (i == 16) ? 8'hAA : 8'h55, i == 19);
    step();
    n_chk++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL multi_b_early: done=%b want 0", b_done); end
    step();
    n_chk++; if (b_done !== 1'b1 || b_pass !== 1'b0) begin n_fail++; $display("FAIL multi_b_done: done=%b pass=%b want 1 0", b_done, b_pass); end
    n_chk++; if (b_cnt !== 8'd2) begin n_fail++; $display("FAIL multi_b_cnt: got %0d want 2", b_cnt); end
    n_chk++; if (b_ffa !== 6'h03 || b_ffs !== 8'h01) begin n_fail++; $display("FAIL multi_b_first: addr=%h syn=%h want 03 01", b_ffa, b_ffs); end
    n_chk++; if (a_cnt !== 8'd2 || a_ffa !== 6'h03) begin n_fail++; $display("FAIL multi_a: cnt=%0d addr=%h want 2 03", a_cnt, a_ffa); end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [6];
    logic [1:0] want [6];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
    want[3] = 2'd3; want[4] = 2'd3; want[5] = 2'd3;
    do_start();
    for (int k = 0; k < 6; k++) begin
      rd(6'(k), 8'hFF, 8'h00, 1'b0);
      if (k >= 1) seq[k-1] = c_cnt;
    end
    step();
    seq[5] = c_cnt;
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (seq[k] !== want[k]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, seq[k], want[k]); end
    end
    n_chk++; if (a_cnt !== 8'd6) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d want 6", a_cnt); end
    n_chk++; if (c_ffa !== 6'h00 || c_ffs !== 8'hFF) begin n_fail++; $display("FAIL sat_first: addr=%h syn=%h want 00 ff", c_ffa, c_ffs); end
  endtask

  task automatic test_restart();
    do_start();
    rd(6'd1, 8'h11, 8'h00, 1'b0);
    step();
    n_chk++; if (a_fail !== 1'b1) begin n_fail++; $display("FAIL restart_pre: fail=%b want 1", a_fail); end
    rd(6'd2, 8'h11, 8'h00, 1'b0);
    // read 2 is in flight in every instance; restart now
    clr_counts();
    do_start();
    n_chk++; if (a_cv !== 1'b0 || a_ce !== 1'b0) begin n_fail++; $display("FAIL restart_cmp: cv=%b ce=%b want 0 0", a_cv, a_ce); end
    n_chk++; if (a_fail !== 1'b0 || a_cnt !== 8'd0) begin n_fail++; $display("FAIL restart_fail: fail=%b cnt=%0d want 0 0", a_fail, a_cnt); end
    n_chk++; if (a_ffa !== 6'd0 || a_ffs !== 8'd0) begin n_fail++; $display("FAIL restart_first: addr=%h syn=%h want 0 0", a_ffa, a_ffs); end
    n_chk++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL restart_state: busy=%b done=%b want 1 0", a_busy, a_done); end
    n_chk++; if (b_fail !== 1'b0) begin n_fail++; $display("FAIL restart_b_fail: fail=%b want 0", b_fail); end
    step(); step();
    n_chk++; if (cv_a !== 0 || cv_b !== 0) begin n_fail++; $display("FAIL restart_flush: cv_a=%0d cv_b=%0d want 0 0", cv_a, cv_b); end
    // start and test_end together: start wins
    start = 1'b1; test_end = 1'b1;
    step();
    start = 1'b0; test_end = 1'b0;
    step(); step(); step();
    n_chk++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin n_fail++; $display("FAIL start_te_a: busy=%b done=%b want 1 0", a_busy, a_done); end
    n_chk++; if (b_busy !== 1'b1 || b_done !== 1'b0) begin n_fail++; $display("FAIL start_te_b: busy=%b done=%b want 1 0", b_busy, b_done); end
  endtask

  task automatic test_reset_ignored();
    rd(6'd7, 8'h11, 8'h00, 1'b0);
    step(); step();
    test_end = 1'b1;
    step();
    test_end = 1'b0;
    n_chk++; if (b_fail !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL drain_pre: fail=%b busy=%b want 1 1", b_fail, b_busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++; if (a_fail !== 1'b0 || a_cnt !== 8'd0 || a_ffa !== 6'd0 || a_ffs !== 8'd0) begin n_fail++; $display("FAIL midrst_a_res: fail=%b cnt=%0d addr=%h syn=%h want 0 0 0 0", a_fail, a_cnt, a_ffa, a_ffs); end
    n_chk++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0 || a_cv !== 1'b0) begin n_fail++; $display("FAIL midrst_a_state: busy=%b done=%b pass=%b cv=%b want 0 0 0 0", a_busy, a_done, a_pass, a_cv); end
    n_chk++; if (b_fail !== 1'b0 || b_cnt !== 8'd0 || b_busy !== 1'b0 || b_done !== 1'b0) begin n_fail++; $display("FAIL midrst_b: fail=%b cnt=%0d busy=%b done=%b want 0 0 0 0", b_fail, b_cnt, b_busy, b_done); end
    // reads in IDLE are ignored
    clr_counts();
    for (int i = 0; i < 3; i++) rd(6'(i), 8'h11, 8'h00, 1'b0);
    step(); step(); step();
    n_chk++; if (cv_a !== 0 || cv_b !== 0 || a_fail !== 1'b0) begin n_fail++; $display("FAIL idle_reads: cv_a=%0d cv_b=%0d fail=%b want 0 0 0", cv_a, cv_b, a_fail); end
    // reach DONE with a clean run, then reads are ignored there too
    do_start();
    test_end = 1'b1;
    step();
    test_end = 1'b0;
    step(); step();
    n_chk++; if (a_done !== 1'b1 || b_done !== 1'b1) begin n_fail++; $display("FAIL done_reach: a=%b b=%b want 1 1", a_done, b_done); end
    clr_counts();
    for (int i = 0; i < 3; i++) rd(6'(i), 8'h11, 8'h00, 1'b0);
    step(); step(); step();
    n_chk++; if (cv_a !== 0 || cv_b !== 0) begin n_fail++; $display("FAIL done_reads: cv_a=%0d cv_b=%0d want 0 0", cv_a, cv_b); end
    n_chk++; if (a_pass !== 1'b1 || b_pass !== 1'b1 || a_fail !== 1'b0) begin n_fail++; $display("FAIL done_hold: pass_a=%b pass_b=%b fail=%b want 1 1 0", a_pass, b_pass, a_fail); end
  endtask

  initial begin
    clr_counts();
    test_reset();
    test_all_pass();
    test_single_fault();
    test_multi_fault();
    test_saturation();
    test_restart();
    test_reset_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_resp_analyzer.md
# bist_resp_analyzer

Read-side response analyzer for the SRAM BIST. The BIST engine drives addresses and write data toward the SRAM through the address/data muxes. This block sits on the return path: it accepts each BIST read request with its expected data, aligns it to the SRAM read latency, and compares it against the SRAM output. It reports a pipelined per-read compare result, a sticky fail flag, a saturating fail count, and the first failing address and syndrome. It signals test completion to the BIST controller with a `done`/`pass` handshake.

## Interface
- `ADDR_W`, 6, SRAM address width (matches the 6-bit BIST address path)
- `DATA_W`, 8, SRAM data width
- `RD_LAT`, 1, SRAM read latency in cycles; legal range 1..4
- `CNT_W`, 8, fail counter width

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse; clears results and begins a test
- `test_end`  in  1  one-cycle pulse; the last read has been issued
- `rd_en`  in  1  BIST read issued to the SRAM this cycle
- `rd_addr`  in  ADDR_W  address of that read
- `exp_data`  in  DATA_W  expected read data for that read
- `mem_q`  in  DATA_W  SRAM read data; valid RD_LAT cycles after `rd_en`
- `cmp_valid`  out  1  registered pulse: a compare completed
- `cmp_err`  out  1  registered pulse: that compare mismatched
- `fail`  out  1  sticky; at least one mismatch since `start`
- `fail_cnt`  out  CNT_W  mismatches since `start`; saturating
- `first_fail_addr`  out  ADDR_W  address of the first mismatch
- `first_fail_syn`  out  DATA_W  `mem_q ^ exp_data` at the first mismatch
- `busy`  out  1  state is ACTIVE or DRAIN
- `done`  out  1  level; state is DONE
- `pass`  out  1  `done & ~fail`

## Operation
- **FSM states:** IDLE, ACTIVE, DRAIN, DONE.
  - IDLE → ACTIVE on `start`.
  - ACTIVE → DRAIN on `test_end`.
  - DRAIN → DONE after exactly RD_LAT cycles in DRAIN (down-counter).
  - DONE holds until `start`, then → ACTIVE.
- **`start` in any state:** next state is ACTIVE. The alignment pipeline is flushed (all valid bits cleared). `fail`, `fail_cnt`, `first_fail_*`, `cmp_*` are cleared. Reads in flight are discarded.
- **`start` and `test_end` in the same cycle:** `start` wins and `test_end` is ignored.
- **Read acceptance:** `rd_en` is accepted only in ACTIVE, including the cycle `test_end` is asserted. It is ignored in IDLE, DRAIN and DONE.
- **Alignment pipeline:** a RD_LAT-deep shift register of {valid, rd_addr, exp_data}. An accepted read enters stage 0. When stage RD_LAT-1 is valid, the block compares `mem_q` against the stored `exp_data`.
- **Compare results:** registered next cycle.
  - `cmp_valid` = 1.
  - `cmp_err` = (`mem_q` != `exp_data`), full-width compare.
- **On a mismatch:**
  - `fail` is set.
  - `fail_cnt` increments, saturating at 2^CNT_W-1 (no wrap).
  - If `fail` was 0 before this mismatch, `first_fail_addr`/`first_fail_syn` are captured. Otherwise they hold.
- **Output hold:** all result outputs hold through DONE and IDLE until `start` or reset.
- **Reset values** (all outputs after `rst_n`=0 sampled): state IDLE; every output 0, including `pass`; pipeline valid bits 0.
- **Reset mid-test:** identical result. Any in-flight reads are dropped.

## Timing
- **Per-read latency:** read accepted at cycle T → compare at T+RD_LAT → `cmp_valid`/`cmp_err`/`fail`/`fail_cnt`/`first_fail_*` visible at T+RD_LAT+1.
- **Back-to-back reads:** one read per cycle, no stall, no backpressure.
- **Start-to-ACTIVE:** `start` at cycle S → ACTIVE and cleared outputs at S+1. `rd_en` at S is not accepted; the first acceptable read is at S+1.
- **End of test:** `test_end` at cycle E → DRAIN for cycles E+1..E+RD_LAT → `done`=1 (and `busy`=0) at E+RD_LAT+1. This is the same cycle the result of a read accepted at E is visible, so `done` never precedes the last result.
- **Busy:** `busy` = 1 from S+1 through E+RD_LAT.

## Test plan
- **All pass (RD_LAT=1):** `start`, then 64 reads of addresses 0..63 with `mem_q`==`exp_data`=0x55, `test_end` on the last read → 64 `cmp_valid` pulses, 0 `cmp_err`. `done`=1 exactly 2 cycles after `test_end`, with `pass`=1 and `fail_cnt`=0.
- **Single fault:** the read of addr 0x2A returns 0x5D against expected 0x55 → `cmp_err` pulse RD_LAT+1 cycles after that `rd_en`. Result `fail`=1, `fail_cnt`=1, `first_fail_addr`=0x2A, `first_fail_syn`=0x08, `pass`=0.
- **Multiple faults (RD_LAT=2):** mismatches at addr 0x03 then 0x10 → `fail_cnt`=2, `first_fail_addr` stays 0x03, and `done` asserts 3 cycles after `test_end`.
- **Saturation (CNT_W=2):** 6 consecutive mismatching reads → `fail_cnt` reads 1, 2, 3, 3, 3, 3.
- **Restart mid-test:** `start` while 1 read is in flight and `fail`=1 → next cycle all results are 0 and the state is ACTIVE. The in-flight read produces no `cmp_valid`. Also check `start` together with `test_end` → stays ACTIVE.
- **Reset and ignored reads:** `rst_n`=0 for 1 cycle mid-DRAIN → all outputs 0 and state IDLE. `rd_en` in IDLE or DONE → no `cmp_valid` ever.
